udp_rx_buf_ctrl: RTL and testbench
==================================

UDP_RX_BUF_CTRL -- requirements
Module: udp_rx_buf_ctrl

Interface
REQ-001 SHALL have parameter MAX_WORDS, default 511, the largest payload word count accepted (RAM is 512 x 32, address 0 unused).
REQ-002 SHALL have port clk  input  1  sole clock, all state changes on the rising edge.
REQ-003 SHALL have port clr  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port rx_done  input  1  receiver frame-complete level; stays high until the receiver is cleared.
REQ-005 SHALL have port rx_data_length  input  16  UDP length field of the frame (8-byte header included).
REQ-006 SHALL have port ram_rd_data  input  32  receive-RAM read data; valid 1 cycle after ram_rd_en.
REQ-007 SHALL have port out_ready  input  1  downstream accepts out_data.
REQ-008 SHALL have port rx_clr  output  1  active-low clear to the receiver; low holds it idle.
REQ-009 SHALL have port ram_rd_en  output  1  RAM read strobe.
REQ-010 SHALL have port ram_rd_addr  output  9  RAM read address.
REQ-011 SHALL have port out_data  output  32  payload word, first byte in [31:24].
REQ-012 SHALL have port out_valid  output  1  out_data valid.
REQ-013 SHALL have port out_last  output  1  out_data is the frame's final word.
REQ-014 SHALL have port out_bytes  output  16  payload byte count of the current frame.
REQ-015 SHALL have port frame_cnt  output  16  frames fully delivered.
REQ-016 SHALL have port drop_cnt  output  16  frames rejected for bad length.
REQ-017 SHALL have port busy  output  1  high whenever state is not IDLE.

Function
REQ-018 SHALL implement states IDLE, CHECK, RD, WAIT, OUT.
REQ-019 rx_clr SHALL be decoded from the state register: 1 only in IDLE, 0 in all other states and during reset, so the receiver cannot overwrite the RAM while it is drained.
REQ-020 IDLE: rx_done sampled 1 -> CHECK; capture rx_data_length into a length register.
REQ-021 CHECK: bytes = len-8 (16-bit); words = ceil(bytes/4) computed as (bytes+3)>>2 in 17 bits.
REQ-022 CHECK: len<9 or words>MAX_WORDS -> drop_cnt+1 (wrap at 16 bits), -> IDLE, no output produced.
REQ-023 CHECK, length valid: out_bytes<=bytes, ram_rd_addr<=1, word index<=1, -> RD.
REQ-024 RD: ram_rd_en=1 for exactly this cycle at ram_rd_addr -> WAIT; ram_rd_en=0 in all other states.
REQ-025 WAIT: out_data<=ram_rd_data, out_valid<=1, out_last<=(index==words) -> OUT.
REQ-026 OUT: out_data, out_valid, out_last held stable while out_ready=0.
REQ-027 OUT with out_ready=1: out_valid<=0, out_last<=0; if last -> frame_cnt+1 (wrap), -> IDLE; else ram_rd_addr+1, index+1, -> RD.
REQ-028 Latency: first out_valid rises at the 3rd rising edge after the edge sampling rx_done=1; with out_ready held 1, one word per 3 cycles.
REQ-029 Padding bytes in the final word SHALL pass through unchanged (receiver zero-fills them).
REQ-030 rx_done high during CHECK..OUT SHALL be ignored; only IDLE samples it.
REQ-031 ram_rd_addr SHALL never exceed MAX_WORDS; no address wrap occurs.

Reset
REQ-032 clr low SHALL immediately force state IDLE, rx_clr=0, ram_rd_en=0, ram_rd_addr=0, out_data=0, out_valid=0, out_last=0, out_bytes=0, frame_cnt=0, drop_cnt=0, busy=0.
REQ-033 Reset mid-frame SHALL discard the frame without counting it; after release rx_clr=1 on the first cycle.

Verification
REQ-034 len=0x0014 (12 bytes), out_ready=1 -> 3 words from addr 1,2,3; out_last on word 3; out_bytes=12; frame_cnt=1.
REQ-035 len=0x000D (5 bytes) -> 2 words, out_last on word 2, word 2 = RAM word incl. zero padding; rx_clr low from CHECK through final OUT.
REQ-036 len=0x0008 and len=0x0810 (2056 bytes, 514 words) -> drop_cnt=2, no out_valid, rx_clr low exactly 1 cycle each.
REQ-037 out_ready low 10 cycles on word 2 -> out_data/out_last stable, no new ram_rd_en until accepted.
REQ-038 clr asserted during OUT of word 2 -> all outputs at reset values asynchronously; next rx_done frame delivered from addr 1, frame_cnt=1.

Source files
------------

// File: rtl/udp_rx_buf_ctrl.sv
// udp_rx_buf_ctrl
//   Drains one received UDP frame from the receive RAM and streams its
//   payload words to a ready/valid consumer. The receiver is held in
//   clear (rx_clr low) for the whole time a frame is being processed so
//   it cannot overwrite the RAM while it is being read.
//
// Ports
//   clk            clock, rising edge
//   clr            asynchronous active-low reset
//   rx_done        receiver frame-complete level (sampled only in IDLE)
//   rx_data_length UDP length field, 8-byte header included
//   ram_rd_data    RAM read data, valid one cycle after ram_rd_en
//   out_ready      downstream accepts out_data
//   rx_clr         active-low clear to the receiver (high only in IDLE)
//   ram_rd_en      RAM read strobe
//   ram_rd_addr    RAM read address (payload words start at 1)
//   out_data       payload word, first byte in [31:24]
//   out_valid      out_data valid
//   out_last       out_data is the final word of the frame
//   out_bytes      payload byte count of the current frame
//   frame_cnt      frames fully delivered (wraps)
//   drop_cnt       frames rejected for bad length (wraps)
//   busy           controller not idle
module udp_rx_buf_ctrl #(
  parameter int unsigned MAX_WORDS = 511
) (
  input  logic        clk,
  input  logic        clr,
  input  logic        rx_done,
  input  logic [15:0] rx_data_length,
  input  logic [31:0] ram_rd_data,
  input  logic        out_ready,
  output logic        rx_clr,
  output logic        ram_rd_en,
  output logic [8:0]  ram_rd_addr,
  output logic [31:0] out_data,
  output logic        out_valid,
  output logic        out_last,
  output logic [15:0] out_bytes,
  output logic [15:0] frame_cnt,
  output logic [15:0] drop_cnt,
  output logic        busy
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CHECK,
    S_RD,
    S_WAIT,
    S_OUT
  } state_t;

  state_t      r_state;
  state_t      w_next;

  logic [15:0] r_len;
  logic [16:0] r_words;

  logic [15:0] w_bytes;
  logic [16:0] w_words;
  logic        w_len_bad;

  assign w_bytes   = r_len - 16'd8;
  assign w_words   = ({1'b0, w_bytes} + 17'd3) >> 2;
  assign w_len_bad = (r_len < 16'd9) || (w_words > 17'(MAX_WORDS));

  // clr is folded in so the receiver stays cleared while reset is held.
  assign rx_clr    = clr && (r_state == S_IDLE);
  assign ram_rd_en = (r_state == S_RD);
  assign busy      = (r_state != S_IDLE);

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) r_state <= S_IDLE;
    else      r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (rx_done) w_next = S_CHECK;
      S_CHECK: w_next = w_len_bad ? S_IDLE : S_RD;
      S_RD:    w_next = S_WAIT;
      S_WAIT:  w_next = S_OUT;
      S_OUT:   if (out_ready) w_next = out_last ? S_IDLE : S_RD;
      default: w_next = S_IDLE;
    endcase
  end

  // The read address doubles as the word index: both start at 1 and
  // advance together, so the last word is the one whose address equals
  // the word count.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      r_len       <= '0;
      r_words     <= '0;
      ram_rd_addr <= '0;
      out_data    <= '0;
      out_valid   <= 1'b0;
      out_last    <= 1'b0;
      out_bytes   <= '0;
      frame_cnt   <= '0;
      drop_cnt    <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (rx_done) r_len <= rx_data_length;
        end
        S_CHECK: begin
          if (w_len_bad) begin
            drop_cnt <= drop_cnt + 16'd1;
          end else begin
            out_bytes   <= w_bytes;
            r_words     <= w_words;
            ram_rd_addr <= 9'd1;
          end
        end
        S_WAIT: begin
          out_data  <= ram_rd_data;
          out_valid <= 1'b1;
          out_last  <= ({8'd0, ram_rd_addr} == r_words);
        end
        S_OUT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            if (out_last) frame_cnt   <= frame_cnt + 16'd1;
            else          ram_rd_addr <= ram_rd_addr + 9'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_udp_rx_buf_ctrl.sv
module tb_udp_rx_buf_ctrl;

  localparam int unsigned MAXW = 511;

  logic        clk = 1'b0;
  logic        clr = 1'b1;
  logic        rx_done = 1'b0;
  logic [15:0] rx_data_length = '0;
  logic [31:0] ram_rd_data = '0;
  logic        out_ready = 1'b1;
  logic        rx_clr;
  logic        ram_rd_en;
  logic [8:0]  ram_rd_addr;
  logic [31:0] out_data;
  logic        out_valid;
  logic        out_last;
  logic [15:0] out_bytes;
  logic [15:0] frame_cnt;
  logic [15:0] drop_cnt;
  logic        busy;

  always #5 clk = ~clk;

  udp_rx_buf_ctrl #(.MAX_WORDS(MAXW)) dut (
    .clk(clk), .clr(clr), .rx_done(rx_done), .rx_data_length(rx_data_length),
    .ram_rd_data(ram_rd_data), .out_ready(out_ready), .rx_clr(rx_clr),
    .ram_rd_en(ram_rd_en), .ram_rd_addr(ram_rd_addr), .out_data(out_data),
    .out_valid(out_valid), .out_last(out_last), .out_bytes(out_bytes),
    .frame_cnt(frame_cnt), .drop_cnt(drop_cnt), .busy(busy)
  );

  // Receive RAM model: registered read, one cycle latency.
  logic [31:0] mem [0:511];
  always @(posedge clk) if (ram_rd_en) ram_rd_data <= mem[ram_rd_addr];

  typedef struct {
    logic [31:0] data;
    logic        last;
    logic [8:0]  addr;
    logic [15:0] bytes;
  } exp_t;

  exp_t        sbq[$];
  int          checks = 0;
  int          errors = 0;
  int          exp_frames = 0;
  int          exp_drops = 0;
  int          ready_mode = 0;
  int          wdx = 0;
  int          stall = 0;
  logic [8:0]  last_rd_addr = '0;
  bit          held = 0;
  logic [31:0] held_data = '0;
  logic        held_last = 1'b0;

  // Downstream ready policy, changed just after each rising edge.
  initial forever begin
    @(posedge clk);
    #2;
    case (ready_mode)
      0: out_ready = 1'b1;
      1: out_ready = ($urandom_range(0, 3) != 0);
      2: begin
        if (out_valid && wdx == 1 && stall < 10) begin
          out_ready = 1'b0;
          stall++;
        end else out_ready = 1'b1;
      end
      default: out_ready = (wdx != 1);
    endcase
  end

  // Monitor: pops the scoreboard whenever a word is handed over.
  always @(negedge clk) begin
    if (clr && ram_rd_en) begin
      last_rd_addr = ram_rd_addr;
      checks++;
      if (ram_rd_addr == 9'd0 || ram_rd_addr > 9'(MAXW)) begin
        errors++;
        $display("FAIL rd_addr_range got %0d allowed 1..%0d", ram_rd_addr, MAXW);
      end
    end
    if (clr && out_valid) begin
      checks++;
      if (ram_rd_en) begin
        errors++;
        $display("FAIL rd_while_valid got ram_rd_en=1 want 0");
      end
      if (sbq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_out got out_valid=1 data=%h want no output", out_data);
      end
      if (held) begin
        checks++;
        if (out_data !== held_data || out_last !== held_last) begin
          errors++;
          $display("FAIL stall_stable got %h/%b want %h/%b", out_data, out_last, held_data, held_last);
        end
      end
      if (out_ready) begin
        held = 0;
        if (sbq.size() != 0) begin
          exp_t e;
          e = sbq.pop_front();
          checks++;
          if (out_data !== e.data || out_last !== e.last || last_rd_addr !== e.addr || out_bytes !== e.bytes) begin
            errors++;
            $display("FAIL word got data=%h last=%b addr=%0d bytes=%0d want data=%h last=%b addr=%0d bytes=%0d",
                     out_data, out_last, last_rd_addr, out_bytes, e.data, e.last, e.addr, e.bytes);
          end
          wdx++;
        end
      end else begin
        held      = 1;
        held_data = out_data;
        held_last = out_last;
      end
    end else begin
      held = 0;
    end
  end

  task automatic check_reset_vals(input string name);
    logic [93:0] v;
    v = {rx_clr, ram_rd_en, ram_rd_addr, out_data, out_valid, out_last,
         out_bytes, frame_cnt, drop_cnt, busy};
    checks++;
    if (v !== '0) begin
      errors++;
      $display("FAIL %s got %h want 0", name, v);
    end
  endtask

  // Reference model: payload layout from the length field alone.
  task automatic prep_frame(input logic [15:0] len, output bit bad, output int words);
    int          bytes;
    logic [31:0] w;
    logic [31:0] mask;
    exp_t        e;
    bytes = int'(len) - 8;
    words = (bytes + 3) / 4;
    bad   = (len < 16'd9) || (words > int'(MAXW));
    if (bad) begin
      words = 0;
      return;
    end
    for (int i = 1; i <= words; i++) begin
      w = $urandom;
      if (i == words && (bytes % 4) != 0) begin
        mask = 32'hFFFF_FFFF << (8 * (4 - bytes % 4));
        w    = w & mask;
      end
      mem[i]  = w;
      e.data  = w;
      e.last  = (i == words);
      e.addr  = 9'(i);
      e.bytes = 16'(bytes);
      sbq.push_back(e);
    end
  endtask

  task automatic send_frame(input logic [15:0] len, input int mode);
    bit bad;
    int words;
    int n;
    int lat;
    int low;
    prep_frame(len, bad, words);
    ready_mode = mode;
    wdx   = 0;
    stall = 0;
    @(negedge clk);
    rx_data_length = len;
    rx_done = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (rx_clr && n < 20);
    checks++;
    if (rx_clr) begin
      errors++;
      $display("FAIL accept_timeout got rx_clr=1 want 0 len=%h", len);
      rx_done = 1'b0;
      return;
    end
    low = 1;
    if (bad) begin
      rx_done = 1'b0;
    end else begin
      // rx_done stays high into RD/WAIT; the controller must ignore it.
      lat = 0;
      while (!out_valid && lat < 10) begin
        @(negedge clk);
        lat++;
        low++;
        if (lat == 2) rx_done = 1'b0;
      end
      rx_done = 1'b0;
      checks++;
      if (lat != 3) begin
        errors++;
        $display("FAIL first_latency got %0d want 3 len=%h", lat, len);
      end
    end
    forever begin
      @(negedge clk);
      if (rx_clr) break;
      low++;
      if (low > 20000) begin
        errors++;
        $display("FAIL drain_timeout got rx_clr=0 want 1 len=%h", len);
        break;
      end
    end
    if (bad) exp_drops++;
    else     exp_frames++;
    if (bad || mode != 1) begin
      n = bad ? 1 : (1 + 3 * words + (mode == 2 ? 10 : 0));
      checks++;
      if (low != n) begin
        errors++;
        $display("FAIL rx_clr_low got %0d want %0d len=%h", low, n, len);
      end
    end
    checks++;
    if (drop_cnt !== 16'(exp_drops) || frame_cnt !== 16'(exp_frames) || busy !== 1'b0 || sbq.size() != 0) begin
      errors++;
      $display("FAIL counters got drop=%0d frame=%0d busy=%b pend=%0d want drop=%0d frame=%0d busy=0 pend=0",
               drop_cnt, frame_cnt, busy, sbq.size(), exp_drops & 16'hFFFF, exp_frames & 16'hFFFF);
      sbq.delete();
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit bad;
    int words;
    int n;
    logic [15:0] len;
    for (int i = 0; i < 512; i++) mem[i] = $urandom;

    #3 clr = 1'b0;
    #1 check_reset_vals("reset_state");
    repeat (2) @(negedge clk);
    clr = 1'b1;
    #1;
    checks++;
    if (rx_clr !== 1'b1) begin
      errors++;
      $display("FAIL rx_clr_after_reset got %b want 1", rx_clr);
    end

    send_frame(16'h0014, 0);
    send_frame(16'h000D, 0);
    send_frame(16'h0008, 0);
    send_frame(16'h0810, 0);
    send_frame(16'd9, 0);
    send_frame(16'd2052, 0);
    send_frame(16'd2053, 0);
    send_frame(16'd24, 2);

    for (int k = 0; k < 40; k++) begin
      case ($urandom_range(0, 9))
        0:       len = 16'($urandom_range(0, 8));
        1:       len = 16'($urandom_range(2053, 65535));
        default: len = 16'($urandom_range(9, 8 + 4 * 24));
      endcase
      send_frame(len, int'($urandom_range(0, 1)));
    end

    // Reset while word 2 of a 4-word frame is waiting for acceptance.
    prep_frame(16'd24, bad, words);
    ready_mode = 3;
    wdx = 0;
    @(negedge clk);
    rx_data_length = 16'd24;
    rx_done = 1'b1;
    n = 0;
    while (!(out_valid && wdx == 1) && n < 200) begin
      @(negedge clk);
      n++;
      if (!rx_clr) rx_done = 1'b0;
    end
    checks++;
    if (!(out_valid && wdx == 1)) begin
      errors++;
      $display("FAIL reach_word2 got valid=%b wdx=%0d want 1/1", out_valid, wdx);
    end
    #3 clr = 1'b0;
    rx_done = 1'b0;
    #1 check_reset_vals("midframe_reset");
    sbq.delete();
    exp_frames = 0;
    exp_drops  = 0;
    ready_mode = 0;
    wdx = 0;
    repeat (3) @(negedge clk);
    check_reset_vals("reset_held");
    clr = 1'b1;
    #1;
    checks++;
    if (rx_clr !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL release got rx_clr=%b busy=%b want 1/0", rx_clr, busy);
    end
    send_frame(16'h0014, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
